fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the CPU's 32-bit instruction ROM (7-bit byte address, word-aligned entries, combinational read gated by an enable).
- Holds the PC and drives the ROM address and enable each cycle.
- Registers the returned word into a one-entry output buffer with a valid/ready handshake toward decode.
- Handles branch/jump redirects from execute, and halts on an all-zero instruction word.

Parameters:
- ADDR_W, 7, ROM byte-address width; PC width.
- DATA_W, 32, instruction width.
- RESET_PC, 0, PC loaded on reset; must be a multiple of 4.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; leaves IDLE and begins fetching.
- rom_addr  output  ADDR_W  byte address to ROM; always equals the PC register.
- rom_en  output  1  ROM read enable; high only in FETCH.
- rom_data  input  DATA_W  ROM read data, valid in the same cycle as rom_addr/rom_en.
- out_valid  output  1  out_instr/out_pc hold a fetched instruction.
- out_ready  input  1  decode accepts when out_valid && out_ready.
- out_instr  output  DATA_W  fetched instruction.
- out_pc  output  ADDR_W  address out_instr was fetched from.
- redirect_valid  input  1  execute requests a PC change this cycle.
- redirect_pc  input  ADDR_W  redirect target; bits [1:0] are forced to 0.
- halted  output  1  sequencer is in HALT.

Behaviour:
- Reset (asynchronous, rst high):
  - state=IDLE, pc=RESET_PC.
  - out_valid=0, out_instr=0, out_pc=0, halted=0, rom_en=0.
  - rst deasserted mid-fetch: the next cycle begins from IDLE; no stale out_valid.
- States:
  - IDLE: rom_en=0. start -> FETCH.
  - FETCH: rom_en=1; buffer loads when empty or being consumed this cycle.
  - HALT: rom_en=0, halted=1; only reset exits.
- Load condition: load = (state==FETCH) && (!out_valid || out_ready) && !redirect_valid.
- On load with rom_data != 0:
  - out_instr<=rom_data, out_pc<=pc, out_valid<=1.
  - pc<=pc+PC_STEP, modulo 2^ADDR_W (124 wraps to 0 for ADDR_W=7).
- On load with rom_data == 0:
  - Nothing is emitted; out_valid<=0 if the buffer is being consumed.
  - pc is unchanged; state<=HALT.
  - An instruction already in the buffer is still held until consumed in HALT.
- Handshake without load:
  - out_valid && out_ready -> out_valid<=0.
  - out_valid && !out_ready -> out_instr, out_pc and out_valid are held stable.
- Latency: one cycle from rom_addr=A to out_valid with out_pc=A. Sustained throughput is one instruction per cycle while out_ready=1.
- redirect_valid (FETCH or IDLE, any buffer state):
  - pc<={redirect_pc[ADDR_W-1:2],2'b00} and out_valid<=0; the buffered instruction is discarded even if out_ready=1.
  - No load occurs that cycle.
  - In IDLE, only pc is updated.
  - Ignored in HALT.
- Priority: rst > redirect_valid > halt detection > load > handshake.
- start while not in IDLE: ignored.

Test Plan:
- ROM[4]=0x00078393, ROM[8]=0x00348093, ROM[12]=0x40708FB3, ROM[16]=0; RESET_PC=4; start, out_ready=1 -> out_valid on cycles 2, 3, 4 with out_pc 4, 8, 12 and those words in order. Then halted=1, out_valid=0, rom_en=0.
- Same ROM; out_ready=0 for 3 cycles after the first valid -> out_instr=0x00078393, out_pc=4 stable, pc stays 8, rom_addr stays 8. On release, the next beat is out_pc=8.
- Redirect during the stall with redirect_pc=0x0E while out_valid=1 -> next cycle out_valid=0, rom_addr=0x0C. The following cycle out_pc=12, out_instr=0x40708FB3.
- pc=124 with nonzero ROM[124] and ROM[0] -> out_pc=124, then out_pc=0 (wrap), no halt.
- Assert rst for half a cycle mid-stream while out_valid=1 -> out_valid, halted and rom_en drop immediately (asynchronous); pc=RESET_PC; nothing is fetched until the next start.
- In HALT, apply redirect_valid and start -> no change: halted=1, rom_en=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: PC, ROM address/enable, one-entry output buffer toward decode.
// Latency 1 cycle from rom_addr to out_valid; fetch stalls while the buffer is full and not being consumed.
module fetch_sequencer #(
    parameter int          ADDR_W   = 7,
    parameter int          DATA_W   = 32,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [DATA_W-1:0] rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_INC  = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] ALIGN_M = ~ADDR_W'(3);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_instr_q, out_instr_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;

    logic              redir;
    logic              load;
    logic [ADDR_W-1:0] redir_tgt;

    assign redir_tgt = redirect_pc & ALIGN_M;
    assign redir     = redirect_valid && ((state_q == S_IDLE) || (state_q == S_FETCH));
    // A redirect in FETCH suppresses the load so the stale fall-through word is never emitted.
    assign load      = (state_q == S_FETCH) && (!out_valid_q || out_ready) && !redirect_valid;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;

        if (redir) begin
            pc_d        = redir_tgt;
            out_valid_d = 1'b0;
        end else if (load) begin
            if (rom_data == '0) begin
                state_d     = S_HALT;
                out_valid_d = 1'b0;
            end else begin
                out_instr_d = rom_data;
                out_pc_d    = pc_q;
                out_valid_d = 1'b1;
                pc_d        = pc_q + PC_INC;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if ((state_q == S_IDLE) && start) begin
            state_d = S_FETCH;
        end
        if (state_q == 2'd3) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= PC_RST;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
        end
    end

    assign rom_addr  = pc_q;
    assign rom_en    = (state_q == S_FETCH);
    assign halted    = (state_q == S_HALT);
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, hand-written corner sequences, randomized stream vs. model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  rom_addr;
    logic        rom_en;
    logic [31:0] rom_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [6:0]  out_pc;
    logic        redirect_valid;
    logic [6:0]  redirect_pc;
    logic        halted;

    logic [31:0] mem [0:31];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign rom_data = rom_en ? mem[rom_addr[6:2]] : 32'h0;

    fetch_sequencer #(
        .ADDR_W(7), .DATA_W(32), .RESET_PC(4), .PC_STEP(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halted(halted)
    );

    typedef struct packed {
        logic        start;
        logic        rdy;
        logic        rv;
        logic [6:0]  rpc;
        logic        ev;
        logic        eh;
        logic        een;
        logic [6:0]  eaddr;
        logic [6:0]  epc;
        logic [31:0] einstr;
    } vec_t;

    vec_t tbl [0:6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [6:0] epc,
                           input logic [31:0] ei, input logic eh, input logic een,
                           input logic [6:0] ea);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
        if (ev) begin
            chk({tag, ".out_pc"}, 32'(out_pc), 32'(epc));
            chk({tag, ".out_instr"}, out_instr, ei);
        end
        chk({tag, ".halted"}, 32'(halted), 32'(eh));
        chk({tag, ".rom_en"}, 32'(rom_en), 32'(een));
        chk({tag, ".rom_addr"}, 32'(rom_addr), 32'(ea));
    endtask

    task automatic tick(input logic s, input logic r, input logic rv, input logic [6:0] rpc);
        @(negedge clk);
        start = s; out_ready = r; redirect_valid = rv; redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[0]  = 32'h00100093;
        mem[1]  = 32'h00078393;
        mem[2]  = 32'h00348093;
        mem[3]  = 32'h40708FB3;
        mem[4]  = 32'h0;
        mem[31] = 32'h00000013;
    endtask

    logic [6:0] exp_pc;
    logic       acc;
    int         n_acc;
    int         zidx;
    bit         done;

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        load_prog();

        // start, emit 4/8/12, halt on the zero word, then HALT ignores redirect/start
        tbl[0] = '{1'b1, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 7'd4,  7'd0,  32'h0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0, 1'b1, 7'd8,  7'd4,  32'h00078393};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0, 1'b1, 7'd12, 7'd8,  32'h00348093};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0, 1'b1, 7'd16, 7'd12, 32'h40708FB3};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 7'h00, 1'b0, 1'b1, 1'b0, 7'd16, 7'd0,  32'h0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 7'h00, 1'b0, 1'b1, 1'b0, 7'd16, 7'd0,  32'h0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 7'h20, 1'b0, 1'b1, 1'b0, 7'd16, 7'd0,  32'h0};

        do_reset();
        chk_out("reset", 1'b0, 7'd0, 32'h0, 1'b0, 1'b0, 7'd4);
        chk("reset.out_pc", 32'(out_pc), 32'h0);
        chk("reset.out_instr", out_instr, 32'h0);

        for (int i = 0; i < 7; i++) begin
            tick(tbl[i].start, tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
            chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].einstr,
                    tbl[i].eh, tbl[i].een, tbl[i].eaddr);
        end

        // stall for 3 cycles then release
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 7'h0);
        tick(1'b0, 1'b0, 1'b0, 7'h0);
        chk_out("stall.first", 1'b1, 7'd4, 32'h00078393, 1'b0, 1'b1, 7'd8);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b0, 7'h0);
            chk_out("stall.hold", 1'b1, 7'd4, 32'h00078393, 1'b0, 1'b1, 7'd8);
        end
        tick(1'b0, 1'b1, 1'b0, 7'h0);
        chk_out("stall.release", 1'b1, 7'd8, 32'h00348093, 1'b0, 1'b1, 7'd12);

        // redirect during stall discards the buffer even with out_ready high
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 7'h0);
        tick(1'b0, 1'b0, 1'b0, 7'h0);
        tick(1'b0, 1'b0, 1'b0, 7'h0);
        chk_out("redir.pre", 1'b1, 7'd4, 32'h00078393, 1'b0, 1'b1, 7'd8);
        tick(1'b0, 1'b1, 1'b1, 7'h0E);
        chk_out("redir.cycle", 1'b0, 7'd0, 32'h0, 1'b0, 1'b1, 7'h0C);
        tick(1'b0, 1'b1, 1'b0, 7'h0);
        chk_out("redir.next", 1'b1, 7'd12, 32'h40708FB3, 1'b0, 1'b1, 7'd16);

        // PC wrap 124 -> 0
        do_reset();
        tick(1'b1, 1'b1, 1'b0, 7'h0);
        tick(1'b0, 1'b1, 1'b1, 7'h7C);
        chk_out("wrap.redir", 1'b0, 7'd0, 32'h0, 1'b0, 1'b1, 7'd124);
        tick(1'b0, 1'b1, 1'b0, 7'h0);
        chk_out("wrap.124", 1'b1, 7'd124, 32'h00000013, 1'b0, 1'b1, 7'd0);
        tick(1'b0, 1'b1, 1'b0, 7'h0);
        chk_out("wrap.0", 1'b1, 7'd0, 32'h00100093, 1'b0, 1'b1, 7'd4);

        // asynchronous reset pulse mid-stream
        #1 rst = 1'b1;
        #1;
        chk_out("arst.now", 1'b0, 7'd0, 32'h0, 1'b0, 1'b0, 7'd4);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 1'b0, 7'h0);
            chk_out("arst.idle", 1'b0, 7'd0, 32'h0, 1'b0, 1'b0, 7'd4);
        end

        // randomized stream with all-nonzero ROM
        for (int i = 0; i < 32; i++) mem[i] = $urandom | 32'h1;
        do_reset();
        tick(1'b1, 1'b1, 1'b0, 7'h0);
        exp_pc = 7'd4;
        n_acc  = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            start          = ($urandom_range(0, 15) == 0);
            out_ready      = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = 7'($urandom);
            #1;
            acc = out_valid && out_ready && !redirect_valid;
            if (acc) begin
                chk("rand.out_pc", 32'(out_pc), 32'(exp_pc));
                chk("rand.out_instr", out_instr, mem[exp_pc[6:2]]);
                exp_pc = exp_pc + 7'd4;
                n_acc++;
            end
            if (redirect_valid) exp_pc = {redirect_pc[6:2], 2'b00};
            chk("rand.rom_en", 32'(rom_en), 32'h1);
            @(posedge clk);
        end
        n_cmp++;
        if (n_acc < 50) begin
            n_err++;
            $display("FAIL rand.throughput: got %0d accepts required >= 50", n_acc);
        end

        // plant a zero word ahead of the stream and drain into HALT
        @(negedge clk);
        zidx = (int'(exp_pc[6:2]) + 3) % 32;
        mem[zidx] = 32'h0;
        start = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            #1;
            if (halted && !out_valid) begin
                done = 1'b1;
            end else begin
                if (out_valid) begin
                    chk("drain.out_pc", 32'(out_pc), 32'(exp_pc));
                    chk("drain.out_instr", out_instr, mem[exp_pc[6:2]]);
                    exp_pc = exp_pc + 7'd4;
                end
                @(negedge clk);
            end
        end
        chk("drain.halted", 32'(halted), 32'h1);
        chk("drain.stop_pc", 32'(exp_pc), 32'(zidx * 4));
        chk("drain.rom_en", 32'(rom_en), 32'h0);
        chk("drain.rom_addr", 32'(rom_addr), 32'(zidx * 4));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
